data_mem_responder: RTL and testbench

Data-memory responder on the processor's data port: it answers the processor's `DataAddr`/`DataOut`/`ReadData`/`WriteData` requests with `DataIn`/`DataDone` after a fixed, parameterised latency. It contains a single-ported word-addressed RAM and a small state machine that models wait states. This lets the processor's Memory1 stall path be exercised at any latency. It sits beside the processor in the top-level system, in place of the ideal single-cycle data memory.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 96 +++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Processor data-port bundle between the CPU and data_mem_responder.
// MemErr exists only when DATA_MEM_ERR_EN is defined.
interface data_mem_responder_if #(
   parameter int WORD_SIZE = 16
);
   logic [WORD_SIZE-1:0] DataAddr;
   logic [WORD_SIZE-1:0] DataOut;
   logic                 ReadData;
   logic                 WriteData;
   logic [WORD_SIZE-1:0] DataIn;
   logic                 DataDone;
`ifdef DATA_MEM_ERR_EN
   logic                 MemErr;

   modport master (output DataAddr, DataOut, ReadData, WriteData,
                   input  DataIn, DataDone, MemErr);
   modport slave  (input  DataAddr, DataOut, ReadData, WriteData,
                   output DataIn, DataDone, MemErr);
`else
   modport master (output DataAddr, DataOut, ReadData, WriteData,
                   input  DataIn, DataDone);
   modport slave  (input  DataAddr, DataOut, ReadData, WriteData,
                   output DataIn, DataDone);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word RAM answering the processor data port with wait states.
// Define DATA_MEM_ERR_EN to add sticky MemErr range/protocol checking.
module data_mem_responder #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 1
) (
   input logic                 Clock,
   input logic                 Resetn,
   data_mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef struct packed {
      logic [WORD_SIZE-1:0] addr;
      logic                 wr;
      logic [WORD_SIZE-1:0] wdata;
   } req_t;

   logic [1:0]           state;
   logic [CW-1:0]        cnt;
   req_t                 req_q, req_in, cmp;
   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        idx;
   logic [WORD_SIZE-1:0] rdata;
   logic                 capture, complete, oor;

   assign req_in   = {bus.DataAddr, bus.WriteData, bus.DataOut};
   assign capture  = (state != WAIT) && (bus.ReadData || bus.WriteData);
   assign complete = (capture && LATENCY == 1) || (state == WAIT && cnt == '0);
   // A single-cycle request completes on its own capture edge, so use the live inputs.
   assign cmp      = (capture && LATENCY == 1) ? req_in : req_q;
   assign idx      = cmp.addr[AW-1:0];

`ifdef DATA_MEM_ERR_EN
   function automatic logic out_of_range(input logic [WORD_SIZE-1:0] a);
      return {1'b0, a} >= (WORD_SIZE+1)'(DEPTH);
   endfunction

   logic both, mismatch;
   assign oor      = out_of_range(cmp.addr);
   assign both     = bus.ReadData && bus.WriteData;
   assign mismatch = (state == WAIT) && (bus.ReadData || bus.WriteData) &&
                     ((bus.DataAddr != req_q.addr) || (bus.WriteData != req_q.wr));

   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn)
         bus.MemErr <= 1'b0;
      else if ((capture && (both || out_of_range(bus.DataAddr))) || mismatch)
         bus.MemErr <= 1'b1;
`else
   assign oor = 1'b0;
`endif

   assign rdata = oor ? '0 : mem[idx];

   // RAM is never reset; Resetn gates the write so an aborted request cannot commit.
   always_ff @(posedge Clock)
      if (Resetn && complete && cmp.wr && !oor)
         mem[idx] <= cmp.wdata;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         req_q      <= '0;
         bus.DataIn <= '0;
      end else begin
         if (complete)
            bus.DataIn <= cmp.wr ? '0 : rdata;
         case (state)
            WAIT: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CW'(1);
            end
            default: begin
               if (capture) begin
                  req_q <= req_in;
                  state <= (LATENCY == 1) ? DONE : WAIT;
                  cnt   <= CNT_INIT;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.DataDone = (state != WAIT);
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders at LATENCY 1, 3 and 4 on one clock.
// Honours DATA_MEM_ERR_EN for the MemErr and out-of-range checks.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [15:0] addr [3];
   logic [15:0] wdat [3];
   logic        rd   [3];
   logic        wr   [3];
   logic [15:0] dout [3];
   logic        done [3];

   data_mem_responder_if #(.WORD_SIZE(16)) b0 ();
   data_mem_responder_if #(.WORD_SIZE(16)) b1 ();
   data_mem_responder_if #(.WORD_SIZE(16)) b2 ();

   assign b0.DataAddr = addr[0]; assign b0.DataOut = wdat[0];
   assign b0.ReadData = rd[0];   assign b0.WriteData = wr[0];
   assign b1.DataAddr = addr[1]; assign b1.DataOut = wdat[1];
   assign b1.ReadData = rd[1];   assign b1.WriteData = wr[1];
   assign b2.DataAddr = addr[2]; assign b2.DataOut = wdat[2];
   assign b2.ReadData = rd[2];   assign b2.WriteData = wr[2];
   assign dout[0] = b0.DataIn; assign done[0] = b0.DataDone;
   assign dout[1] = b1.DataIn; assign done[1] = b1.DataDone;
   assign dout[2] = b2.DataIn; assign done[2] = b2.DataDone;
`ifdef DATA_MEM_ERR_EN
   logic merr [3];
   assign merr[0] = b0.MemErr; assign merr[1] = b1.MemErr; assign merr[2] = b2.MemErr;
`endif

   data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(1))
      u0 (.Clock(clk), .Resetn(rst_n), .bus(b0));
   data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(3))
      u1 (.Clock(clk), .Resetn(rst_n), .bus(b1));
   data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(4))
      u2 (.Clock(clk), .Resetn(rst_n), .bus(b2));

   typedef struct {
      int          k;
      int          due;
      logic [15:0] data;
   } sb_t;
   sb_t sb[$];

   logic [15:0] model [3][256];
   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 4;
   endfunction

   // Completions come back in issue order; compare each at its due cycle.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
         sb_t e;
         e = sb.pop_front();
         chk("done_at_completion", 32'(done[e.k]), 32'd1);
         chk("data_in", 32'(dout[e.k]), 32'(e.data));
      end
   end

   // Called just after a negedge; returns at the negedge of the completion cycle
   // with the request still driven, so the caller may chain back-to-back.
   task automatic req(input int k, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
      int guard, waits;
      logic oor;
      sb_t e;
      rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d;
      guard = 0;
      while (!done[k] && guard < 20) begin @(negedge clk); guard++; end
      chk("capture_timeout", 32'(guard >= 20), 32'd0);
`ifdef DATA_MEM_ERR_EN
      oor = (a[15:8] != 8'd0);
`else
      oor = 1'b0;
`endif
      e.k = k;
      e.due = cyc + lat_of(k);
      e.data = w ? 16'h0 : (oor ? 16'h0 : model[k][a[7:0]]);
      if (w && !oor) model[k][a[7:0]] = d;
      sb.push_back(e);
      @(negedge clk);
      waits = 0;
      while (!done[k] && waits < 20) begin waits++; @(negedge clk); end
      chk("wait_cycles", 32'(waits), 32'(lat_of(k) - 1));
   endtask

   task automatic idle(input int k);
      rd[k] = 1'b0; wr[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic rst_pulse();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic w;
      logic [15:0] a;
      for (int k = 0; k < 3; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
      end
      rst_n = 1'b0;
      #3;
      for (int k = 0; k < 3; k++) begin
         chk("reset_done", 32'(done[k]), 32'd1);
         chk("reset_data", 32'(dout[k]), 32'd0);
`ifdef DATA_MEM_ERR_EN
         chk("reset_merr", 32'(merr[k]), 32'd0);
`endif
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // LATENCY=1: write then read back-to-back, DataDone never drops
      req(0, 1'b0, 1'b1, 16'd5, 16'h1234);
      req(0, 1'b1, 1'b0, 16'd5, 16'h0);
      idle(0);

      // LATENCY=4: preload then read with the request held
      req(2, 1'b0, 1'b1, 16'd3, 16'hBEEF);
      idle(2);
      req(2, 1'b1, 1'b0, 16'd3, 16'h0);
      idle(2);
      repeat (2) @(negedge clk);
      chk("l4_back_to_idle", 32'(done[2]), 32'd1);

      // LATENCY=3: write in the DONE cycle of a read, no IDLE gap
      req(1, 1'b0, 1'b1, 16'd4, 16'h0042);
      idle(1);
      req(1, 1'b1, 1'b0, 16'd4, 16'h0);
      req(1, 1'b0, 1'b1, 16'd7, 16'h00AA);
      req(1, 1'b1, 1'b0, 16'd7, 16'h0);
      idle(1);

      // LATENCY=4: reset aborts an in-flight write
      req(2, 1'b0, 1'b1, 16'd9, 16'h0001);
      req(2, 1'b1, 1'b0, 16'd9, 16'h0);
      idle(2);
      rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 16'd9; wdat[2] = 16'h7777;
      @(negedge clk);
      @(negedge clk);
      chk("l4_wait_before_reset", 32'(done[2]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("reset_abort_done", 32'(done[2]), 32'd1);
      chk("reset_abort_data", 32'(dout[2]), 32'd0);
      wr[2] = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      req(2, 1'b1, 1'b0, 16'd9, 16'h0);
      idle(2);

      // Read and write together behave as a write
      req(0, 1'b1, 1'b1, 16'd2, 16'h5555);
      req(0, 1'b1, 1'b0, 16'd2, 16'h0);
      idle(0);
`ifdef DATA_MEM_ERR_EN
      chk("merr_both", 32'(merr[0]), 32'd1);
      rst_pulse();
      chk("merr_cleared", 32'(merr[0]), 32'd0);
`endif

      // Address above DEPTH: wraps, or errors with the check enabled
      req(0, 1'b0, 1'b1, 16'd0, 16'h0F0F);
      req(0, 1'b1, 1'b0, 16'h0100, 16'h0);
      idle(0);
`ifdef DATA_MEM_ERR_EN
      repeat (3) @(negedge clk);
      chk("merr_range_sticky", 32'(merr[0]), 32'd1);
      rst_pulse();
      chk("merr_range_cleared", 32'(merr[0]), 32'd0);
`endif

      // LATENCY=3 random traffic over a preloaded window
      for (int i = 0; i < 16; i++) req(1, 1'b0, 1'b1, 16'(i), 16'($urandom));
      idle(1);
      for (int i = 0; i < 24; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 16'($urandom_range(0, 15));
         req(1, !w, w, a, 16'($urandom));
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(1);

      repeat (8) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
